// File: rtl/alu_instr_sequencer_pkg.sv
// Shared constants for the single-bus datapath sequencer: the ALU opcode set,
// the IR field positions and the sequencer state encoding.
package alu_instr_sequencer_pkg;

  // ALU opcodes, shared with the datapath and the ALU
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;

  // IR field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_HALT
  } state_t;

  // True for the nine three-register ALU operations this sequencer executes
  function automatic logic isLegalOp(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control/feedback bundle between the sequencer and the datapath.
// The master side is the sequencer; the slave side is the datapath.
interface alu_instr_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout;
  logic        MARin;
  logic        IncPC;
  logic        Read;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        ZLowIn;
  logic        ZLowout;
  logic [15:0] r_out;
  logic [15:0] r_in;
  logic [4:0]  operation;
  logic        busy;
  logic        done;
  logic        fault;

  modport master (
    input  run, ir, mem_ready,
    output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZLowout,
    output r_out, r_in, operation, busy, done, fault
  );

  modport slave (
    output run, ir, mem_ready,
    input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZLowout,
    input  r_out, r_in, operation, busy, done, fault
  );
endinterface

// File: rtl/alu_instr_sequencer_decoder.sv
// 4-to-16 one-hot decoder with enable; used for register bus-drive selects
// and register load enables.
module decoder_4_to_16 (
  input  logic        en_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] dec_o
);

  // One-hot decode of the select, forced to zero while disabled
  always_comb begin
    dec_o = '0;
    if (en_i) dec_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute sequencer for the single-bus datapath. Fetches one
// instruction through MAR/MDR into IR, then runs it as Ra <= Rb op Rc.
// Controls are a Moore decode of the state plus the IR register fields.
module alu_instr_sequencer
  import alu_instr_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                   clk,
  input logic                   clr,
  alu_instr_sequencer_if.master bus
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        fault_q, fault_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        legal;
  logic        rOutEn, rInEn;
  logic [3:0]  rOutSel;

  assign opcode = bus.ir[OPC_MSB:OPC_LSB];
  assign ra     = bus.ir[RA_MSB:RA_LSB];
  assign rb     = bus.ir[RB_MSB:RB_LSB];
  assign rc     = bus.ir[RC_MSB:RC_LSB];
  assign legal  = isLegalOp(opcode);

  // State, memory-wait counter and sticky fault flag
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Next-state sequencing; run is only looked at in IDLE and T5
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: if (bus.run && !fault_q) state_d = ST_T0;
      ST_T0: begin
        state_d = ST_T1;
        wait_d  = '0;
      end
      ST_T1: begin
        if (bus.mem_ready) begin
          state_d = ST_T2;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        if (legal) begin
          state_d = ST_T4;
        end else begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_T4: state_d = ST_T5;
      ST_T5: state_d = bus.run ? ST_T0 : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode; register selects come from the IR fields
  always_comb begin
    bus.PCout     = 1'b0;
    bus.MARin     = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Read      = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MDRout    = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.ZLowIn    = 1'b0;
    bus.ZLowout   = 1'b0;
    bus.operation = '0;
    bus.done      = 1'b0;
    bus.busy      = (state_q != ST_IDLE);
    bus.fault     = fault_q;
    rOutEn        = 1'b0;
    rOutSel       = rb;
    rInEn         = 1'b0;
    case (state_q)
      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
      end
      ST_T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T3: begin
        if (legal) begin
          rOutEn  = 1'b1;
          bus.Yin = 1'b1;
        end
      end
      ST_T4: begin
        rOutEn        = 1'b1;
        rOutSel       = rc;
        bus.ZLowIn    = 1'b1;
        bus.operation = opcode;
      end
      ST_T5: begin
        bus.ZLowout = 1'b1;
        rInEn       = (ra != 4'd0);
        bus.done    = 1'b1;
      end
      default: ;
    endcase
  end

  decoder_4_to_16 u_rOutDec (
    .en_i  (rOutEn),
    .sel_i (rOutSel),
    .dec_o (bus.r_out)
  );

  decoder_4_to_16 u_rInDec (
    .en_i  (rInEn),
    .sel_i (ra),
    .dec_o (bus.r_in)
  );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer. Each instruction is expanded
// into its expected cycle-by-cycle phase timeline and every cycle's outputs
// are compared against the controls that phase should produce.
module tb_alu_instr_sequencer;

  localparam int MEM_WAIT_MAX = 15;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  alu_instr_sequencer_if bus();

  alu_instr_sequencer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   tickCount = 0;
  int   doneSeen  = 0;
  logic faultModel;

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pack the DUT outputs in a fixed order
  function automatic logic [63:0] observed();
    return {14'd0, bus.PCout, bus.MARin, bus.IncPC, bus.Read, bus.MDRin,
            bus.MDRout, bus.IRin, bus.Yin, bus.ZLowIn, bus.ZLowout,
            bus.r_out, bus.r_in, bus.operation, bus.busy, bus.done, bus.fault};
  endfunction

  // Outputs that a given phase of the instruction must show
  function automatic logic [63:0] expected(input string ph, input logic [31:0] irv, input logic f);
    logic [9:0]  ctl;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [4:0]  op;
    logic        busyE;
    logic        doneE;
    int          opc;
    int          ra;
    int          rb;
    int          rc;
    ctl   = '0;
    ro    = '0;
    ri    = '0;
    op    = '0;
    doneE = 1'b0;
    busyE = (ph != "IDLE");
    opc   = int'(irv[31:27]);
    ra    = int'(irv[26:23]);
    rb    = int'(irv[22:19]);
    rc    = int'(irv[18:15]);
    // ctl bits: PCout MARin IncPC Read MDRin MDRout IRin Yin ZLowIn ZLowout
    if (ph == "T0") ctl = 10'b1110000000;
    else if (ph == "T1") ctl = 10'b0001100000;
    else if (ph == "T2") ctl = 10'b0000011000;
    else if (ph == "T3") begin
      if (opc >= 3 && opc <= 11) begin
        ctl = 10'b0000000100;
        ro  = 16'(1) << rb;
      end
    end else if (ph == "T4") begin
      ctl = 10'b0000000010;
      ro  = 16'(1) << rc;
      op  = irv[31:27];
    end else if (ph == "T5") begin
      ctl   = 10'b0000000001;
      ri    = (ra == 0) ? 16'd0 : (16'(1) << ra);
      doneE = 1'b1;
    end
    return {14'd0, ctl, ro, ri, op, busyE, doneE, f};
  endfunction

  // Drive inputs for the next edge, then sample just after it
  task automatic tick(input logic runV, input logic memV);
    bus.run       = runV;
    bus.mem_ready = memV;
    @(posedge clk);
    #1;
    tickCount++;
    checkOutput("bus_onehot",
                64'($countones({bus.PCout, bus.MDRout, bus.ZLowout, bus.r_out}) <= 1), 64'd1);
    if (bus.done) doneSeen++;
  endtask

  task automatic expectPhase(input string ph, input logic [31:0] irv);
    checkOutput(ph, observed(), expected(ph, irv, faultModel));
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge
  task automatic doReset();
    clr = 1'b0;
    #1;
    faultModel = 1'b0;
    checkOutput("reset_async", observed(), expected("IDLE", 32'd0, 1'b0));
    @(posedge clk);
    #1;
    checkOutput("reset_held", observed(), expected("IDLE", 32'd0, 1'b0));
    clr = 1'b1;
  endtask

  // One instruction from T0 to T5 (or HALT); starts from IDLE or T5
  task automatic runInstr(input logic [31:0] irv, input int waits, output logic halted);
    int opc;
    halted = 1'b0;
    bus.ir = irv;
    opc    = int'(irv[31:27]);
    tick(1'b1, 1'($urandom));
    expectPhase("T0", irv);
    tick(1'($urandom), 1'($urandom));
    expectPhase("T1", irv);
    for (int j = 0; j < waits; j++) begin
      tick(1'($urandom), 1'b0);
      if (j == MEM_WAIT_MAX - 1) begin
        faultModel = 1'b1;
        expectPhase("HALT", irv);
        halted = 1'b1;
        return;
      end
      expectPhase("T1", irv);
    end
    tick(1'($urandom), 1'b1);
    expectPhase("T2", irv);
    tick(1'($urandom), 1'($urandom));
    expectPhase("T3", irv);
    if (!(opc >= 3 && opc <= 11)) begin
      tick(1'($urandom), 1'($urandom));
      faultModel = 1'b1;
      expectPhase("HALT", irv);
      halted = 1'b1;
      return;
    end
    tick(1'($urandom), 1'($urandom));
    expectPhase("T4", irv);
    tick(1'($urandom), 1'($urandom));
    expectPhase("T5", irv);
  endtask

  // HALT must persist while run is high, until the reset clears it
  task automatic holdHaltThenReset(input logic [31:0] irv);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'($urandom));
      expectPhase("HALT", irv);
    end
    doReset();
    tick(1'b0, 1'b0);
    expectPhase("IDLE", irv);
  endtask

  // Randomized instruction stream mixing legal, illegal and slow-memory cases
  task automatic applyStimulus(input int count);
    logic [31:0] irv;
    logic [4:0]  op;
    int          v;
    int          waits;
    int          r;
    logic        halted;
    logic        atT5;
    atT5 = 1'b0;
    for (int n = 0; n < count; n++) begin
      if ($urandom % 8 == 0) begin
        v  = int'($urandom % 23);
        op = (v < 3) ? 5'(v) : 5'(v + 9);
      end else begin
        op = 5'(3 + ($urandom % 9));
      end
      irv = {op, 27'($urandom)};
      r   = int'($urandom % 10);
      if (r == 0) waits = MEM_WAIT_MAX;
      else if (r == 1) waits = MEM_WAIT_MAX - 1;
      else waits = int'($urandom % 4);
      runInstr(irv, waits, halted);
      atT5 = 1'b0;
      if (halted) begin
        tick(1'($urandom), 1'($urandom));
        expectPhase("HALT", irv);
        doReset();
      end else if ($urandom % 2 == 0) begin
        atT5 = 1'b1;
      end else begin
        tick(1'b0, 1'($urandom));
        expectPhase("IDLE", irv);
      end
    end
    if (atT5) begin
      tick(1'b0, 1'b0);
      expectPhase("IDLE", irv);
    end
  endtask

  initial begin
    logic [31:0] irv;
    logic        halted;
    int          startTick;
    int          startDone;

    clr           = 1'b0;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir        = '0;
    faultModel    = 1'b0;
    #7;
    checkOutput("reset_state", observed(), expected("IDLE", 32'd0, 1'b0));
    #5;
    clr = 1'b1;
    tick(1'b0, 1'b0);
    expectPhase("IDLE", 32'd0);

    // ror R4 <= R4 ror R3 with memory ready immediately
    irv = 32'h5221_8000;
    runInstr(irv, 0, halted);
    checkOutput("ror_t5_r_in", 64'(bus.r_in), 64'h0010);
    tick(1'b0, 1'b1);
    expectPhase("IDLE", irv);

    // rol targeting R0: result never written
    irv = 32'h5809_8000;
    runInstr(irv, 0, halted);
    checkOutput("rol_r0_r_in", 64'(bus.r_in), 64'h0000);
    checkOutput("rol_r0_zlowout", 64'(bus.ZLowout), 64'd1);
    tick(1'b0, 1'b0);
    expectPhase("IDLE", irv);

    // Memory wait: three stalls, then the longest stall that still completes
    irv = {5'b00011, 4'd5, 4'd6, 4'd7, 15'd0};
    runInstr(irv, 3, halted);
    tick(1'b0, 1'b0);
    expectPhase("IDLE", irv);
    runInstr(irv, MEM_WAIT_MAX - 1, halted);
    checkOutput("wait_max_done", 64'(bus.done), 64'd1);
    tick(1'b0, 1'b0);
    expectPhase("IDLE", irv);

    // Memory timeout
    runInstr(irv, MEM_WAIT_MAX, halted);
    checkOutput("timeout_halted", 64'(halted), 64'd1);
    holdHaltThenReset(irv);

    // Illegal opcode 11111
    irv = 32'hF800_0000;
    runInstr(irv, 0, halted);
    holdHaltThenReset(irv);

    // Two back-to-back instructions, run dropped during the second one
    startTick = tickCount;
    startDone = doneSeen;
    runInstr({5'b00100, 4'd1, 4'd2, 4'd3, 15'd0}, 0, halted);
    irv = {5'b00101, 4'd9, 4'd10, 4'd11, 15'd0};
    bus.ir = irv;
    tick(1'b1, 1'b1);
    expectPhase("T0", irv);
    tick(1'b1, 1'b1);
    expectPhase("T1", irv);
    tick(1'b0, 1'b1);
    expectPhase("T2", irv);
    tick(1'b0, 1'b1);
    expectPhase("T3", irv);
    tick(1'b0, 1'b1);
    expectPhase("T4", irv);
    tick(1'b0, 1'b1);
    expectPhase("T5", irv);
    checkOutput("b2b_cycles", 64'(tickCount - startTick), 64'd12);
    checkOutput("b2b_done", 64'(doneSeen - startDone), 64'd2);
    tick(1'b0, 1'b0);
    expectPhase("IDLE", irv);

    // Reset while in T4: abandon the instruction, no later register write
    irv = {5'b00110, 4'd7, 4'd1, 4'd2, 15'd0};
    bus.ir = irv;
    tick(1'b1, 1'b1);
    expectPhase("T0", irv);
    tick(1'b0, 1'b1);
    expectPhase("T1", irv);
    tick(1'b0, 1'b1);
    expectPhase("T2", irv);
    tick(1'b0, 1'b1);
    expectPhase("T3", irv);
    tick(1'b0, 1'b1);
    expectPhase("T4", irv);
    doReset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b1);
      expectPhase("IDLE", irv);
    end

    applyStimulus(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Control sequencer for the single-bus datapath. It drives the datapath's register-enable, bus-drive, memory and ALU-opcode control inputs to fetch one instruction and execute it as a three-register ALU operation. Supported operations are add, sub, and, or, shifts, ror and rol. The block sits beside the datapath top level and replaces testbench-driven control signals. The datapath's IR output feeds back to it for decode.

## Interface
Parameters:
- `MEM_WAIT_MAX`, 15: maximum cycles to wait in T1 for `mem_ready` before a timeout fault.

Ports:
- `clk`  in  1  rising-edge clock shared with the datapath.
- `clr`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; while high, instructions execute back to back.
- `ir`  in  32  datapath IR contents. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- `mem_ready`  in  1  memory data valid on MDatain.
- `PCout`, `MARin`, `IncPC`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `ZLowIn`, `ZLowout`  out  1 each  datapath controls.
- `r_out`  out  16  one-hot R0–R15 bus-drive selects.
- `r_in`  out  16  one-hot R0–R15 load enables.
- `operation`  out  5  ALU opcode.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on T5.
- `fault`  out  1  sticky; set by an illegal opcode or a memory timeout. Cleared only by `clr`.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT.
- IDLE: all controls 0. If `run`=1 and `fault`=0, go to T0.
- T0: `PCout`, `MARin`, `IncPC`. Go to T1.
- T1: `Read`, `MDRin`.
  - If `mem_ready`=1, go to T2.
  - Otherwise stay in T1 and increment the wait counter.
  - When the counter reaches `MEM_WAIT_MAX`, set `fault` and go to HALT.
- T2: `MDRout`, `IRin`. Go to T3.
- T3: decode `ir` opcode.
  - Legal opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011.
  - Legal: assert `r_out[Rb]` and `Yin`, go to T4.
  - Illegal: all controls 0, set `fault`, go to HALT.
- T4: `r_out[Rc]`, `ZLowIn`, `operation` = opcode. Go to T5.
- T5: `ZLowout`, `r_in[Ra]`, `done`.
  - If Ra=0, `r_in` stays all-zero (R0 is not writable).
  - Go to T0 if `run`=1, else IDLE.
- HALT: all controls 0. Remain until `clr`.
- `run` is sampled only in IDLE and T5. Dropping `run` mid-instruction completes that instruction.
- Bus-drive invariant: at most one of `PCout`, `MDRout`, `ZLowout`, `r_out[*]` is high in any cycle.
- `operation` is 0 in every state except T4.

## Timing
- Reset (`clr`=0, asynchronous):
  - State goes to IDLE; wait counter and `fault` go to 0.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - Reset mid-instruction abandons it; no partial register write occurs after reset.
- Controls are a Moore decode of the state register plus `ir` fields.
  - `ir` is stable from the cycle after T2 onward, because the IR loads at the end of T2.
  - Datapath registers capture on the `clk` edge that ends the state asserting the enable.
- Instruction latency is 6 cycles (T0–T5) with `mem_ready` already high in T1. Each extra wait cycle adds 1.
- Back-to-back throughput is one instruction per 6 cycles; T5 goes directly to T0 with no IDLE cycle.
- Wait counter: 4-bit, cleared on T1 entry. A timeout occurs after exactly `MEM_WAIT_MAX` cycles in T1 without `mem_ready`.
- `done` is high exactly one cycle per completed instruction. `busy` is low in the cycle after T5 only if the block returns to IDLE.

## Structure
- Shared package: opcode localparams (the 9 legal codes), state encoding, and IR field bit positions. The datapath and the ALU use the same opcode constants.
- Sub-module: `decoder_4_to_16`, instantiated twice, once for `r_out` and once for `r_in`. It has an enable input so the output is all-zero when not in T3/T4 or T5 respectively.
- The next-state logic, output decode and wait counter all live in the top module.

## Test plan
- Reset mid-T4 (assert `clr` low) → all outputs 0 the same cycle; state IDLE; `fault`=0; no `r_in` bit asserted afterward.
- `run`=1, `ir`=0x5221_8000 (ror, Ra=4, Rb=4, Rc=3), `mem_ready` tied high → T0..T5 in 6 cycles, then:
  - T3: `r_out`=0x0010, `Yin`=1.
  - T4: `r_out`=0x0008, `operation`=01010, `ZLowIn`=1.
  - T5: `r_in`=0x0010, `done`=1.
- rol with Ra=0 (`ir`=0x5809_8000) → T5 has `ZLowout`=1, `r_in`=0x0000, `done`=1.
- `mem_ready` held low 3 cycles in T1 → T1 lasts 4 cycles, then T2 and normal completion. `mem_ready` held low 15 cycles → `fault`=1, HALT, all controls 0.
- Opcode 11111 → T3 drives nothing; `fault`=1; HALT persists with `run`=1 until `clr`.
- `run` high for two instructions, then low during the second one's T2 → second instruction completes, `done` pulses twice, 12 cycles total, return to IDLE; bus-drive one-hot invariant checked every cycle.
